// File: rtl/deser_8bit.sv
// Serial-to-parallel byte assembler with valid/ready on both sides and a single output holding register.
// Define DESER_8BIT_MSB_FIRST_EN to have the first received bit land in out[7] instead of out[0].
module deser_8bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   output logic [7:0] out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_any
);

   logic [7:0] shift_p0;
   logic [2:0] cnt;
   logic       in_beat;
   logic       done;
   logic [7:0] word;

   function automatic logic [2:0] bit_pos(input logic [2:0] c);
`ifdef DESER_8BIT_MSB_FIRST_EN
      return 3'd7 - c;
`else
      return c;
`endif
   endfunction

   // Only the final bit of a byte can stall, and only while the holding register is still full.
   assign in_ready = !(cnt == 3'd7 && out_valid && !out_ready);
   assign in_beat  = in_valid && in_ready && !clear;
   assign done     = in_beat && (cnt == 3'd7);
   assign out_any  = |out;

   always_comb begin
      word = shift_p0;
      word[bit_pos(cnt)] = in_bit;
   end

   // Stage p0: shift register and counter; output holding register loads on completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_p0  <= 8'h00;
         cnt       <= 3'd0;
         out       <= 8'h00;
         out_valid <= 1'b0;
      end else begin
         if (clear) begin
            shift_p0 <= 8'h00;
            cnt      <= 3'd0;
         end else if (in_beat) begin
            shift_p0 <= done ? 8'h00 : word;
            cnt      <= cnt + 3'd1;
         end
         if (done) begin
            out       <= word;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_deser_8bit.sv
// Self-checking bench for deser_8bit: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based byte model. Honours DESER_8BIT_MSB_FIRST_EN.
module tb_deser_8bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_ready;
   logic [7:0] out;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_any;

   int n_cmp = 0;
   int n_fail = 0;

   deser_8bit dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
      .out_any(out_any)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r, c, v, b, o;
      logic       chk_rdy;
      logic       exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_out;
   } vec_t;

   // Reference model: received bits kept in a queue, a byte emitted once eight have arrived.
   bit         q[$];
   logic [7:0] mout = 8'h00;
   bit         mvalid = 1'b0;
   bit         model_ok = 1'b0;
   logic       rdy_pre;

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] y;
      for (int i = 0; i < 8; i++) y[i] = x[7-i];
      return y;
   endfunction

   function automatic logic [7:0] order(input logic [7:0] lsb_first);
`ifdef DESER_8BIT_MSB_FIRST_EN
      return rev8(lsb_first);
`else
      return lsb_first;
`endif
   endfunction

   function bit model_ready();
      return !(q.size() == 7 && mvalid && !out_ready);
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit         ob, fin;
      logic [7:0] w;
      if (!rst_n) begin
         q.delete();
         mout = 8'h00;
         mvalid = 1'b0;
         model_ok = 1'b1;
         return;
      end
      ob  = mvalid && out_ready;
      fin = 1'b0;
      if (clear) q.delete();
      else if (in_valid && model_ready()) begin
         q.push_back(in_bit);
         if (q.size() == 8) begin
            w = 8'h00;
            for (int i = 0; i < 8; i++) w[i] = q[i];
            mout = order(w);
            mvalid = 1'b1;
            fin = 1'b1;
            q.delete();
         end
      end
      if (ob && !fin) mvalid = 1'b0;
   endtask

   task automatic cycle(input logic r, c, v, b, o, input bit use_model);
      @(negedge clk);
      rst_n = r; clear = c; in_valid = v; in_bit = b; out_ready = o;
      #1;
      rdy_pre = in_ready;
      if (use_model && model_ok) check("in_ready", in_ready, model_ready());
      @(posedge clk);
      model_step();
      #1;
      if (use_model) begin
         check("out_valid", out_valid, mvalid);
         check("out", out, mout);
         check("out_any", out_any, |mout);
      end
   endtask

   task automatic send_byte(input logic [7:0] lsb_first, input logic o);
      for (int i = 0; i < 8; i++) cycle(1, 0, 1, lsb_first[i], o, 1);
   endtask

   function automatic vec_t mk(input logic r, c, v, b, o, chk, er, eov, input logic [7:0] eo);
      vec_t t;
      t.r = r; t.c = c; t.v = v; t.b = b; t.o = o;
      t.chk_rdy = chk; t.exp_rdy = er; t.exp_ov = eov; t.exp_out = eo;
      return t;
   endfunction

   initial begin
      vec_t       tbl[$];
      logic [7:0] bits_a;
      logic [7:0] exp_a;
      logic [7:0] bytes3 [3];
      int         pulses;
      int         pulse_at [3];
      bit         rdy_dropped;

      // Basic byte: stream 1,0,1,0,0,0,0,0 with the consumer always ready.
      bits_a = 8'b0000_0101;
      exp_a  = order(bits_a);
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0, 8'h00));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, 0, 1, bits_a[i], 1, 1, 1, (i == 7), (i == 7) ? exp_a : 8'h00));
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, exp_a));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, exp_a));

      foreach (tbl[k]) begin
         cycle(tbl[k].r, tbl[k].c, tbl[k].v, tbl[k].b, tbl[k].o, 0);
         if (tbl[k].chk_rdy) check($sformatf("tbl%0d_in_ready", k), rdy_pre, tbl[k].exp_rdy);
         check($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].exp_ov);
         check($sformatf("tbl%0d_out", k), out, tbl[k].exp_out);
         check($sformatf("tbl%0d_out_any", k), out_any, |tbl[k].exp_out);
      end

      // Backpressure: 0xFF held, 7 more bits, 8th stalls until out_ready rises.
      cycle(0, 0, 0, 0, 0, 1);
      send_byte(8'hFF, 0);
      check("bp_first_out", out, 8'hFF);
      check("bp_first_valid", out_valid, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1, 0, 1, (i == 0), 0, 1);
      cycle(1, 0, 1, 1, 0, 1);
      check("bp_stall_ready", rdy_pre, 1'b0);
      check("bp_stall_out", out, 8'hFF);
      cycle(1, 0, 1, 0, 1, 1);
      check("bp_release_ready", rdy_pre, 1'b1);
      check("bp_release_valid", out_valid, 1'b1);
      check("bp_release_out", out, order(8'h01));

      // Back-to-back streaming: 24 bits, three pulses eight cycles apart.
      cycle(0, 0, 0, 0, 1, 1);
      for (int j = 0; j < 3; j++) bytes3[j] = 8'($urandom);
      pulses = 0;
      rdy_dropped = 1'b0;
      for (int n = 0; n < 24; n++) begin
         cycle(1, 0, 1, bytes3[n/8][n%8], 1, 1);
         if (!rdy_pre) rdy_dropped = 1'b1;
         if (out_valid) begin
            if (pulses < 3) begin
               pulse_at[pulses] = n;
               check($sformatf("stream_byte%0d", pulses), out, order(bytes3[pulses]));
            end
            pulses++;
         end
      end
      check("stream_pulses", 8'(pulses), 8'd3);
      check("stream_ready_held", rdy_dropped, 1'b0);
      check("stream_spacing", 8'(pulse_at[2] - pulse_at[0]), 8'd16);

      // Clear after 3 bits (with a discarded beat), then 8 zeros.
      cycle(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 1, 1);
      cycle(1, 1, 1, 1, 1, 1);
      send_byte(8'h00, 1);
      check("clr_out", out, 8'h00);
      check("clr_out_any", out_any, 1'b0);
      check("clr_valid", out_valid, 1'b1);

      // Reset mid-byte with an unconsumed output, then a fresh byte.
      cycle(0, 0, 0, 0, 0, 1);
      send_byte(8'hFF, 0);
      for (int i = 0; i < 5; i++) cycle(1, 0, 1, 1, 0, 1);
      cycle(0, 0, 1, 1, 0, 1);
      check("rst_out", out, 8'h00);
      check("rst_valid", out_valid, 1'b0);
      check("rst_out_any", out_any, 1'b0);
      send_byte(8'h96, 1);
      check("rst_fresh_ready", rdy_pre, 1'b1);
      check("rst_fresh_out", out, order(8'h96));
      check("rst_fresh_valid", out_valid, 1'b1);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++)
         cycle($urandom_range(0, 99) != 0, $urandom_range(0, 29) == 0,
               $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
